// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing for the truth-table sweeper: FSM states,
// vector space size and the dwell counter width.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NUM_VEC  = 8;
    localparam int VEC_W    = 3;
    localparam int HOLD_MAX = 255;
    // Wide enough to hold HOLD_MAX-1, the largest terminal value.
    localparam int DWELL_W  = $clog2(HOLD_MAX + 1);

endpackage

// File: rtl/tts_dwell_counter.sv
// Modulo-HOLD dwell counter. tc_o flags the last cycle of each dwell and
// serves as the sample strobe for the sweeper FSM.
module tts_dwell_counter
    import truth_table_sweeper_pkg::*;
#(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(HOLD - 1);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // With HOLD=1 LAST is zero, so every enabled cycle is terminal.
    assign tc_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c} through vectors 0..7, samples f1/f2 at the end of each dwell
// and compares against golden truth tables, accumulating error statistics.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                 HOLD   = 10,
    parameter logic [NUM_VEC-1:0] EXP_F1 = 8'h00,
    parameter logic [NUM_VEC-1:0] EXP_F2 = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       f1,
    input  logic       f2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_err_vec,
    output logic       first_err_valid,
    output logic [1:0] state_dbg
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [3:0]       err_q, err_d;
    logic [VEC_W-1:0] fev_q, fev_d;
    logic             fevv_q, fevv_d;

    logic running;
    logic accept;
    logic sample;
    logic mismatch;

    // start is a plain level: it is honoured whenever no sweep is running.
    assign running  = (state_q == ST_RUN);
    assign accept   = !running && start;
    assign mismatch = (f1 != EXP_F1[vec_q]) || (f2 != EXP_F2[vec_q]);

    tts_dwell_counter #(
        .HOLD (HOLD)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!running),
        .en_i  (running),
        .tc_o  (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (sample && vec_q == LAST_VEC) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // vec_q drives a/b/c directly; the 3-bit wrap after vector 7 returns the
    // pins to 000 on entry to DONE.
    always_comb begin
        vec_d  = vec_q;
        err_d  = err_q;
        fev_d  = fev_q;
        fevv_d = fevv_q;
        if (accept) begin
            vec_d  = '0;
            err_d  = '0;
            fev_d  = '0;
            fevv_d = 1'b0;
        end else if (sample) begin
            vec_d = vec_q + 1'b1;
            if (mismatch) begin
                err_d = err_q + 4'd1;
                if (!fevv_q) begin
                    fev_d  = vec_q;
                    fevv_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        {a, b, c}       = vec_q;
        busy            = (state_q == ST_RUN);
        done            = (state_q == ST_DONE);
        pass            = (state_q == ST_DONE) && (err_q == 4'd0);
        err_count       = err_q;
        first_err_vec   = fev_q;
        first_err_valid = fevv_q;
        state_dbg       = state_q;
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a HOLD=10 and a HOLD=1 instance,
// each wrapped around a majority/parity model with injectable faults.
module tb_truth_table_sweeper;

    logic       clk;
    int         n_vec;
    int         n_err;

    // Instance A: HOLD=10
    logic       rst_n_a, start_a, f1_a, f2_a;
    logic       a_a, b_a, c_a, busy_a, done_a, pass_a, fevv_a;
    logic [3:0] err_a;
    logic [2:0] fev_a;
    logic [1:0] st_a;
    logic       f1_stuck_a;

    // Instance B: HOLD=1
    logic       rst_n_b, start_b, f1_b, f2_b;
    logic       a_b, b_b, c_b, busy_b, done_b, pass_b, fevv_b;
    logic [3:0] err_b;
    logic [2:0] fev_b;
    logic [1:0] st_b;
    logic       f2_inv_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit under test: f1 = majority, f2 = odd parity, plus faults.
    assign f1_a = ((a_a & b_a) | (a_a & c_a) | (b_a & c_a)) & ~f1_stuck_a;
    assign f2_a = a_a ^ b_a ^ c_a;
    assign f1_b = (a_b & b_b) | (a_b & c_b) | (b_b & c_b);
    assign f2_b = a_b ^ b_b ^ c_b ^ f2_inv_b;

    truth_table_sweeper #(.HOLD(10), .EXP_F1(8'hE8), .EXP_F2(8'h96)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a),
        .a(a_a), .b(b_a), .c(c_a), .f1(f1_a), .f2(f2_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_vec(fev_a), .first_err_valid(fevv_a), .state_dbg(st_a)
    );

    truth_table_sweeper #(.HOLD(1), .EXP_F1(8'hE8), .EXP_F2(8'h96)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b),
        .a(a_b), .b(b_b), .c(c_b), .f1(f1_b), .f2(f2_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_vec(fev_b), .first_err_valid(fevv_b), .state_dbg(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results_a(input string tag, input logic d, input logic p,
                                 input logic [3:0] e, input logic [2:0] fv, input logic fvv);
        chk({tag, ".busy"}, 32'(busy_a), 32'd0);
        chk({tag, ".done"}, 32'(done_a), 32'(d));
        chk({tag, ".pass"}, 32'(pass_a), 32'(p));
        chk({tag, ".err"},  32'(err_a),  32'(e));
        chk({tag, ".fev"},  32'(fev_a),  32'(fv));
        chk({tag, ".fevv"}, 32'(fevv_a), 32'(fvv));
        chk({tag, ".abc"},  32'({a_a, b_a, c_a}), 32'd0);
    endtask

    task automatic chk_results_b(input string tag, input logic d, input logic p,
                                 input logic [3:0] e, input logic [2:0] fv, input logic fvv);
        chk({tag, ".busy"}, 32'(busy_b), 32'd0);
        chk({tag, ".done"}, 32'(done_b), 32'(d));
        chk({tag, ".pass"}, 32'(pass_b), 32'(p));
        chk({tag, ".err"},  32'(err_b),  32'(e));
        chk({tag, ".fev"},  32'(fev_b),  32'(fv));
        chk({tag, ".fevv"}, 32'(fevv_b), 32'(fvv));
        chk({tag, ".abc"},  32'({a_b, b_b, c_b}), 32'd0);
    endtask

    // Pulse start for one edge; returns at the falling edge after that edge (cycle k).
    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    // Walk HOLD=10 sweep from cycle k, checking each vector and busy; optional
    // start pulses at the given cycle offsets (negative = none).
    task automatic sweep_a(input string tag, input int poke0, input int poke1);
        for (int i = 0; i < 80; i++) begin
            chk({tag, ".busy_run"}, 32'(busy_a), 32'd1);
            chk({tag, ".abc_run"},  32'({a_a, b_a, c_a}), 32'(i / 10));
            if (i == poke0 || i == poke1) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n_a    = 1'b0;
        rst_n_b    = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        f1_stuck_a = 1'b0;
        f2_inv_b   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk_results_a("rst_a", 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        chk_results_b("rst_b", 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_a.busy", 32'(busy_a), 32'd0);
        chk("idle_a.done", 32'(done_a), 32'd0);

        // 1: matching circuit, HOLD=10
        pulse_a();
        sweep_a("t1", -1, -1);
        chk_results_a("t1_end", 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk_results_a("t1_hold", 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);

        // 2: f1 stuck at 0, restart from DONE clears results on the start edge
        f1_stuck_a = 1'b1;
        pulse_a();
        chk("t2_clr.done", 32'(done_a), 32'd0);
        chk("t2_clr.pass", 32'(pass_a), 32'd0);
        chk("t2_clr.err",  32'(err_a),  32'd0);
        chk("t2_clr.fevv", 32'(fevv_a), 32'd0);
        sweep_a("t2", -1, -1);
        chk_results_a("t2_end", 1'b1, 1'b0, 4'd4, 3'd3, 1'b1);

        // 3: start while busy (cycles 35 and 55) is ignored
        pulse_a();
        sweep_a("t3", 35, 55);
        chk_results_a("t3_end", 1'b1, 1'b0, 4'd4, 3'd3, 1'b1);

        // 4: asynchronous reset while vec=4
        pulse_a();
        repeat (45) @(negedge clk);
        chk("t4_pre.abc", 32'({a_a, b_a, c_a}), 32'd4);
        chk("t4_pre.err", 32'(err_a), 32'd1);
        #1 rst_n_a = 1'b0;
        #1;
        chk_results_a("t4_async", 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n_a = 1'b1;
        repeat (5) @(negedge clk);
        chk_results_a("t4_idle", 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);

        // 5: HOLD=1, matching then f2 inverted
        pulse_b();
        for (int i = 0; i < 8; i++) begin
            chk("t5.busy_run", 32'(busy_b), 32'd1);
            chk("t5.abc_run",  32'({a_b, b_b, c_b}), 32'(i));
            @(negedge clk);
        end
        chk_results_b("t5_end", 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);

        f2_inv_b = 1'b1;
        pulse_b();
        chk("t6_clr.done", 32'(done_b), 32'd0);
        chk("t6_clr.busy", 32'(busy_b), 32'd1);
        chk("t6_clr.err",  32'(err_b),  32'd0);
        chk("t6_clr.fevv", 32'(fevv_b), 32'd0);
        repeat (8) @(negedge clk);
        chk_results_b("t6_end", 1'b1, 1'b0, 4'd8, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
